mutex_arbiter: RTL
==================

MUTEX_ARBITER -- requirements
Module: mutex_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8, meaning max grant cycles before forced hand-over under contention; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_a  input  1  requester A wants the shared resource; level, held while needed.
REQ-005 req_b  input  1  requester B wants the shared resource; level, held while needed.
REQ-006 gnt_a  output  1  A owns the resource; registered.
REQ-007 gnt_b  output  1  B owns the resource; registered.
REQ-008 phase  output  3  enable vector for the mutex gate: [0]=A phase, [1]=B phase, [2]=guard phase; registered.
REQ-009 timeout  output  1  one-cycle pulse: a grant was revoked by HOLD_MAX expiry.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 The block SHALL implement FSM states IDLE, GRANT_A, GRANT_B, GUARD.
REQ-012 The block SHALL keep a one-bit priority pointer (0 = A preferred, 1 = B preferred), reset to 0.
REQ-013 IDLE or GUARD, sampled requests: only req_a -> GRANT_A; only req_b -> GRANT_B; both -> requester named by pointer; neither -> IDLE.
REQ-014 Grant latency SHALL be one cycle: request sampled at edge n gives grant visible after edge n.
REQ-015 Hold counter width SHALL be ceil(log2(HOLD_MAX+1)); it loads 1 on entering a GRANT state, increments per grant cycle, saturates at HOLD_MAX.
REQ-016 GRANT_X with req_X sampled low SHALL go to GUARD; pointer set to favour the other requester.
REQ-017 GRANT_X with counter == HOLD_MAX and other request sampled high SHALL go to GUARD, pulse timeout during that GUARD cycle, and set pointer to the other requester.
REQ-018 GRANT_X with counter == HOLD_MAX and other request low SHALL stay in GRANT_X; no timeout.
REQ-019 Release takes precedence over expiry when both occur at the same edge: timeout SHALL stay low.
REQ-020 GUARD SHALL last exactly one cycle with gnt_a = gnt_b = 0, then act as IDLE per REQ-013.
REQ-021 phase SHALL equal {state==GUARD, gnt_b, gnt_a}; never more than one bit set.
REQ-022 gnt_a and gnt_b SHALL never be high in the same cycle.
REQ-023 Requests changing while granted to the other requester SHALL not affect the current grant.

Reset
REQ-024 rst_n low SHALL immediately (no clock) force state IDLE, pointer 0, counter 0, gnt_a=gnt_b=0, phase=000, timeout=0, busy=0.
REQ-025 Reset mid-grant SHALL drop the grant asynchronously; first edge after rst_n rises evaluates per REQ-013.

Verification (HOLD_MAX=4)
REQ-026 Reset: rst_n=0 with req_a=req_b=1 -> all outputs 0 throughout, no clock edge needed.
REQ-027 req_a high for edges 1..3, low at edge 4 -> gnt_a/phase=001 after edges 1..3, phase=100 after edge 4, phase=000 after edge 5, timeout=0.
REQ-028 Both requests high continuously from reset release -> gnt_a 4 cycles, GUARD with timeout=1, gnt_b 4 cycles, GUARD with timeout=1, gnt_a; pattern repeats.
REQ-029 req_a alone for 10 cycles -> gnt_a high 10 consecutive cycles, timeout never asserted, then GUARD.
REQ-030 Simultaneous release and expiry: req_a drops at edge where counter=4 while req_b=1 -> GUARD with timeout=0, then gnt_b.
REQ-031 rst_n pulsed low while gnt_b=1 -> gnt_b and phase[1] fall before next edge; after release with both requests high, gnt_a granted first.

Source files
------------

// File: rtl/mutex_arbiter.sv
// mutex_arbiter
//   Two-requester mutual-exclusion arbiter with a round-robin priority
//   pointer, a bounded hold time under contention and a one-cycle guard gap
//   between successive owners.
//
// Ports
//   clk      sole clock, rising edge
//   rst_n    asynchronous active-low reset
//   req_a    requester A wants the resource (level)
//   req_b    requester B wants the resource (level)
//   gnt_a    A owns the resource (registered)
//   gnt_b    B owns the resource (registered)
//   phase    mutex gate enables {guard, B, A} (registered, one-hot or zero)
//   timeout  one-cycle pulse in the guard cycle that follows a forced hand-over
//   busy     high whenever the arbiter is not idle
//
// Parameter
//   HOLD_MAX grant cycles allowed before a forced hand-over when the other
//            side is waiting (1..255)

module mutex_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic [2:0] phase,
  output logic       timeout,
  output logic       busy
);

  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2,
    GUARD   = 2'd3
  } state_t;

  state_t        state, next_state;
  logic          ptr, next_ptr;
  logic [CW-1:0] cnt, next_cnt;
  logic          next_timeout;

  // State, pointer, hold counter and all registered outputs. The outputs are
  // decoded from next_state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      cnt     <= '0;
      gnt_a   <= 1'b0;
      gnt_b   <= 1'b0;
      phase   <= 3'b000;
      timeout <= 1'b0;
    end else begin
      state   <= next_state;
      ptr     <= next_ptr;
      cnt     <= next_cnt;
      gnt_a   <= (next_state == GRANT_A);
      gnt_b   <= (next_state == GRANT_B);
      phase   <= {next_state == GUARD, next_state == GRANT_B, next_state == GRANT_A};
      timeout <= next_timeout;
    end
  end

  // Next-state logic. A release is checked before expiry so that a
  // simultaneous drop of the owner's request never reports a timeout.
  // Expiry only forces a hand-over when the other side is actually waiting;
  // otherwise the counter just saturates and the owner keeps the resource.
  always_comb begin
    next_state   = state;
    next_ptr     = ptr;
    next_cnt     = cnt;
    next_timeout = 1'b0;
    case (state)
      IDLE, GUARD: begin
        if (req_a && (!req_b || !ptr)) begin
          next_state = GRANT_A;
          next_cnt   = CNT_ONE;
        end else if (req_b) begin
          next_state = GRANT_B;
          next_cnt   = CNT_ONE;
        end else begin
          next_state = IDLE;
          next_cnt   = '0;
        end
      end
      GRANT_A: begin
        if (!req_a) begin
          next_state = GUARD;
          next_ptr   = 1'b1;
          next_cnt   = '0;
        end else if ((cnt == HOLD_LIM) && req_b) begin
          next_state   = GUARD;
          next_ptr     = 1'b1;
          next_cnt     = '0;
          next_timeout = 1'b1;
        end else if (cnt != HOLD_LIM) begin
          next_cnt = cnt + CNT_ONE;
        end
      end
      GRANT_B: begin
        if (!req_b) begin
          next_state = GUARD;
          next_ptr   = 1'b0;
          next_cnt   = '0;
        end else if ((cnt == HOLD_LIM) && req_a) begin
          next_state   = GUARD;
          next_ptr     = 1'b0;
          next_cnt     = '0;
          next_timeout = 1'b1;
        end else if (cnt != HOLD_LIM) begin
          next_cnt = cnt + CNT_ONE;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule
